srv_write_buffer: RTL and testbench
===================================

Name: srv_write_buffer

Overview:
Posted-write buffer between the bus arbiter's server port and the RAM server. Writes get their ack after a fixed 1 cycle and are queued in a FIFO. The FIFO drains to the RAM in order. Reads are strictly ordered behind buffered writes, then forwarded to the RAM, with the read data returned to the arbiter.

Parameters:
DATA_WIDTH, 8, data bus width
ADDR_WIDTH, 4, address bus width
FIFO_DEPTH, 4, buffered write entries; power of 2, minimum 2
PTR_WIDTH, 2, log2(FIFO_DEPTH)

Ports:
clk  in  1  single clock, rising edge
reset  in  1  synchronous, active-low
up_address  in  ADDR_WIDTH  request address from arbiter
up_rq  in  1  request from arbiter
up_ack  out  1  one-cycle ack to arbiter
up_wr_ni  in  1  1=write, 0=read
up_dataW  in  DATA_WIDTH  write data
up_dataR  out  DATA_WIDTH  read data, valid while up_ack=1 on a read
dn_address  out  ADDR_WIDTH  address to RAM
dn_rq  out  1  request to RAM
dn_ack  in  1  ack from RAM
dn_wr_ni  out  1  direction to RAM
dn_dataW  out  DATA_WIDTH  write data to RAM
dn_dataR  in  DATA_WIDTH  read data from RAM, sampled when dn_ack=1
full  out  1  count==FIFO_DEPTH
empty  out  1  count==0
level  out  PTR_WIDTH+1  current occupancy

Behaviour:
Interface clocking: one clock clk; reset is synchronous and active-low, port reset (reset==0 at a rising edge resets).

Reset values:
- up_ack=0, up_dataR=0.
- dn_rq=0, dn_wr_ni=0, dn_address=0, dn_dataW=0.
- FIFO pointers=0, count=0, empty=1, full=0, level=0, FSM=IDLE.
- Reset mid-operation discards all buffered writes and any pending read. No RAM write is completed after reset.

Bus protocol, both sides:
- Requester holds rq, address, wr_ni and dataW stable until it sees ack=1.
- ack is a one-cycle registered pulse.
- A request is never accepted in the cycle where the block's own ack is high. This prevents double acceptance.

Write path:
- Accept condition at edge N: up_rq & up_wr_ni & !full & !up_ack.
- At edge N: push {up_address, up_dataW}; up_ack=1 during cycle N+1.
- If full, hold the request and give no ack. It is accepted on the first edge where a slot is free.
- If a pop happens at the same edge, it frees the slot at that edge, so the write is accepted at that edge.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Pointers wrap modulo FIFO_DEPTH.

Drain FSM (states IDLE, WR_ISSUE, RD_ISSUE, RD_RESP):
- IDLE, !empty: go to WR_ISSUE. dn_rq=1, dn_wr_ni=1, dn_address/dn_dataW=head entry.
- WR_ISSUE, dn_ack=1: pop head, dn_rq=0, go to IDLE. dn_rq stays low for at least 1 cycle between transactions.
- IDLE, empty, pending read (up_rq & !up_wr_ni & !up_ack): go to RD_ISSUE. dn_rq=1, dn_wr_ni=0, dn_address=up_address.
- Writes always drain before any read; a read never bypasses a buffered write.
- RD_ISSUE, dn_ack=1: register up_dataR=dn_dataR, up_ack=1 next cycle, dn_rq=0, go to RD_RESP.
- RD_RESP: up_ack=1 for exactly 1 cycle, then go to IDLE.
- Read latency with a zero-wait RAM and empty FIFO: ack 3 cycles after up_rq is first sampled.

Flags:
- full, empty and level are registered and consistent with count after each edge.

Optional Feature:
Macro: SRV_WRBUF_READ_FORWARD_EN.

With the macro defined:
- A read whose address matches any valid FIFO entry completes from the buffer.
- The youngest matching entry supplies the data.
- up_ack comes 1 cycle after acceptance, with no RAM access.
- A write pushed at the same edge is not visible to a read at that edge.

Without the macro:
- Reads always wait for empty, then go to the RAM as above.

Test Plan:
- Reset: hold reset=0 for 2 cycles with up_rq=1 -> all outputs at reset values, no up_ack, empty=1.
- Single write: addr 4'h5, data 8'hA7 -> up_ack 1 cycle after acceptance; dn_rq=1 with addr 5/data A7/wr_ni=1 until dn_ack; level 1->0.
- Fill: 5 back-to-back writes, addr 0..4, with dn_ack held 0 -> 4 acked, full=1, level=4; 5th acked only after the first dn_ack pop; RAM sees writes in order 0,1,2,3,4.
- Read-after-write ordering: write 8'h3C to addr 9, then read addr 9 (forward feature off) -> dn read issued only after the write is popped; up_dataR=8'h3C with up_ack pulse.
- Simultaneous push/pop at full: level stays 4; no entry lost or duplicated (scoreboard of 16 random writes).
- With SRV_WRBUF_READ_FORWARD_EN: writes of 11 then 22 to addr 2, RAM stalled, then read addr 2 -> up_dataR=8'h22 in 1 cycle, dn_rq stays write-only.

Source files
------------

// File: rtl/srv_write_buffer.sv
`default_nettype none
// ============================================================================
// Module   : srv_write_buffer
// Purpose  : Posted-write buffer between the bus arbiter's server port and
//            the RAM server. Writes are acked one cycle after acceptance and
//            queued in a FIFO that drains to the RAM in order. Reads wait
//            until every buffered write has drained, then go to the RAM. The
//            RAM read data is returned to the arbiter.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk         in   single clock, rising edge
//   reset       in   synchronous, active-low
//   up_address  in   request address from arbiter
//   up_rq       in   request from arbiter
//   up_ack      out  one-cycle registered ack to arbiter
//   up_wr_ni    in   1 = write, 0 = read
//   up_dataW    in   write data from arbiter
//   up_dataR    out  read data, valid while up_ack=1 on a read
//   dn_address  out  address to RAM
//   dn_rq       out  request to RAM
//   dn_ack      in   one-cycle ack from RAM
//   dn_wr_ni    out  direction to RAM
//   dn_dataW    out  write data to RAM
//   dn_dataR    in   read data from RAM, sampled when dn_ack=1
//   full        out  occupancy == FIFO_DEPTH (registered)
//   empty       out  occupancy == 0 (registered)
//   level       out  current occupancy (registered)
// Build option:
//   SRV_WRBUF_READ_FORWARD_EN - a read that hits a buffered write completes
//   from the buffer (youngest matching entry) one cycle after acceptance,
//   with no RAM access.
// ============================================================================
module srv_write_buffer #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int PTR_WIDTH  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] up_address,
  input  logic                  up_rq,
  output logic                  up_ack,
  input  logic                  up_wr_ni,
  input  logic [DATA_WIDTH-1:0] up_dataW,
  output logic [DATA_WIDTH-1:0] up_dataR,
  output logic [ADDR_WIDTH-1:0] dn_address,
  output logic                  dn_rq,
  input  logic                  dn_ack,
  output logic                  dn_wr_ni,
  output logic [DATA_WIDTH-1:0] dn_dataW,
  input  logic [DATA_WIDTH-1:0] dn_dataR,
  output logic                  full,
  output logic                  empty,
  output logic [PTR_WIDTH:0]    level
);

  localparam int                 c_CNT_W = PTR_WIDTH + 1;
  localparam logic [c_CNT_W-1:0] c_DEPTH = c_CNT_W'(FIFO_DEPTH);

  localparam logic [1:0] c_ST_IDLE     = 2'd0;
  localparam logic [1:0] c_ST_WR_ISSUE = 2'd1;
  localparam logic [1:0] c_ST_RD_ISSUE = 2'd2;
  localparam logic [1:0] c_ST_RD_RESP  = 2'd3;

  // --------------------------------------------------------------------------
  // Storage and state
  // --------------------------------------------------------------------------
  logic [ADDR_WIDTH-1:0] mem_addr_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] mem_data_q [FIFO_DEPTH];
  logic [PTR_WIDTH-1:0]  wr_ptr_q, rd_ptr_q;
  logic [c_CNT_W-1:0]    count_q, count_d;
  logic                  full_q, empty_q;

  logic [1:0]            state_q, state_d;
  logic                  up_ack_q, up_ack_d;
  logic [DATA_WIDTH-1:0] up_dataR_q, up_dataR_d;
  logic                  dn_rq_q, dn_rq_d;
  logic                  dn_wr_ni_q, dn_wr_ni_d;
  logic [ADDR_WIDTH-1:0] dn_address_q, dn_address_d;
  logic [DATA_WIDTH-1:0] dn_dataW_q, dn_dataW_d;

  logic                  w_push, w_pop, w_rd_pending;
  logic                  w_rd_done;
  logic                  w_fwd_acc;
  logic [DATA_WIDTH-1:0] w_fwd_data;

  // Pop is the RAM completing the head write. A pop frees its slot at the
  // same edge, so a write waiting on a full FIFO is accepted at that edge.
  assign w_pop  = (state_q == c_ST_WR_ISSUE) & dn_ack;
  assign w_push = up_rq & up_wr_ni & ~up_ack_q & (~full_q | w_pop);

  // A read is only considered while our own ack is low, which also blocks
  // re-accepting the request in the cycle it is being acked.
  assign w_rd_pending = up_rq & ~up_wr_ni & ~up_ack_q;
  assign w_rd_done    = (state_q == c_ST_RD_ISSUE) & dn_ack;

`ifdef SRV_WRBUF_READ_FORWARD_EN
  logic                  w_fwd_hit;
  logic [DATA_WIDTH-1:0] w_fwd_hit_data;

  // Scan oldest to youngest over valid entries; the last match wins so the
  // youngest write supplies the data. Entries pushed at this edge are not
  // yet counted, so they are invisible to a read at the same edge.
  always_comb begin
    w_fwd_hit      = 1'b0;
    w_fwd_hit_data = '0;
    for (int k = 0; k < FIFO_DEPTH; k++) begin
      if (c_CNT_W'(k) < count_q) begin
        if (mem_addr_q[rd_ptr_q + PTR_WIDTH'(k)] == up_address) begin
          w_fwd_hit      = 1'b1;
          w_fwd_hit_data = mem_data_q[rd_ptr_q + PTR_WIDTH'(k)];
        end
      end
    end
  end

  // Forwarding is not allowed once a RAM read for this request is underway.
  assign w_fwd_acc  = w_rd_pending & w_fwd_hit &
                      ((state_q == c_ST_IDLE) | (state_q == c_ST_WR_ISSUE));
  assign w_fwd_data = w_fwd_hit_data;
`else
  assign w_fwd_acc  = 1'b0;
  assign w_fwd_data = '0;
`endif

  // --------------------------------------------------------------------------
  // FIFO
  // --------------------------------------------------------------------------
  always_comb begin
    count_d = count_q + c_CNT_W'(w_push) - c_CNT_W'(w_pop);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      if (w_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (w_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
      full_q  <= (count_d == c_DEPTH);
      empty_q <= (count_d == '0);
    end
  end

  // Entry contents need no reset: validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (w_push) begin
      mem_addr_q[wr_ptr_q] <= up_address;
      mem_data_q[wr_ptr_q] <= up_dataW;
    end
  end

  // --------------------------------------------------------------------------
  // Drain FSM: state and registered outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= c_ST_IDLE;
      up_ack_q     <= 1'b0;
      up_dataR_q   <= '0;
      dn_rq_q      <= 1'b0;
      dn_wr_ni_q   <= 1'b0;
      dn_address_q <= '0;
      dn_dataW_q   <= '0;
    end else begin
      state_q      <= state_d;
      up_ack_q     <= up_ack_d;
      up_dataR_q   <= up_dataR_d;
      dn_rq_q      <= dn_rq_d;
      dn_wr_ni_q   <= dn_wr_ni_d;
      dn_address_q <= dn_address_d;
      dn_dataW_q   <= dn_dataW_d;
    end
  end

  // Next state. Buffered writes always win over a pending read, so a read
  // never overtakes a write that was posted before it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      c_ST_IDLE: begin
        if (!empty_q)          state_d = c_ST_WR_ISSUE;
        else if (w_rd_pending) state_d = c_ST_RD_ISSUE;
      end
      c_ST_WR_ISSUE: if (dn_ack) state_d = c_ST_IDLE;
      c_ST_RD_ISSUE: if (dn_ack) state_d = c_ST_RD_RESP;
      c_ST_RD_RESP:  state_d = c_ST_IDLE;
      default:       state_d = c_ST_IDLE;
    endcase
  end

  // Next values of the registered outputs. Every RAM transaction returns
  // through IDLE, which guarantees dn_rq is low for a cycle in between.
  always_comb begin
    dn_rq_d      = dn_rq_q;
    dn_wr_ni_d   = dn_wr_ni_q;
    dn_address_d = dn_address_q;
    dn_dataW_d   = dn_dataW_q;
    case (state_q)
      c_ST_IDLE: begin
        if (!empty_q) begin
          dn_rq_d      = 1'b1;
          dn_wr_ni_d   = 1'b1;
          dn_address_d = mem_addr_q[rd_ptr_q];
          dn_dataW_d   = mem_data_q[rd_ptr_q];
        end else if (w_rd_pending) begin
          dn_rq_d      = 1'b1;
          dn_wr_ni_d   = 1'b0;
          dn_address_d = up_address;
        end
      end
      c_ST_WR_ISSUE,
      c_ST_RD_ISSUE: if (dn_ack) dn_rq_d = 1'b0;
      default: ;
    endcase

    up_ack_d = w_push | w_rd_done | w_fwd_acc;
    if (w_rd_done)      up_dataR_d = dn_dataR;
    else if (w_fwd_acc) up_dataR_d = w_fwd_data;
    else                up_dataR_d = up_dataR_q;
  end

  assign up_ack     = up_ack_q;
  assign up_dataR   = up_dataR_q;
  assign dn_rq      = dn_rq_q;
  assign dn_wr_ni   = dn_wr_ni_q;
  assign dn_address = dn_address_q;
  assign dn_dataW   = dn_dataW_q;
  assign full       = full_q;
  assign empty      = empty_q;
  assign level      = count_q;

endmodule
`default_nettype wire

// File: tb/tb_srv_write_buffer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_srv_write_buffer
// Purpose  : Directed self-checking bench for srv_write_buffer with a simple
//            stallable RAM model that logs every RAM transaction it accepts.
// Revision : 1.0 - initial release
// ============================================================================
module tb_srv_write_buffer;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] up_address;
  logic       up_rq;
  logic       up_ack;
  logic       up_wr_ni;
  logic [7:0] up_dataW;
  logic [7:0] up_dataR;
  logic [3:0] dn_address;
  logic       dn_rq;
  logic       dn_ack;
  logic       dn_wr_ni;
  logic [7:0] dn_dataW;
  logic [7:0] dn_dataR;
  logic       full;
  logic       empty;
  logic [2:0] level;

  always #5 clk = ~clk;

  srv_write_buffer #(
    .DATA_WIDTH(8),
    .ADDR_WIDTH(4),
    .FIFO_DEPTH(4),
    .PTR_WIDTH (2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .up_address(up_address),
    .up_rq     (up_rq),
    .up_ack    (up_ack),
    .up_wr_ni  (up_wr_ni),
    .up_dataW  (up_dataW),
    .up_dataR  (up_dataR),
    .dn_address(dn_address),
    .dn_rq     (dn_rq),
    .dn_ack    (dn_ack),
    .dn_wr_ni  (dn_wr_ni),
    .dn_dataW  (dn_dataW),
    .dn_dataR  (dn_dataR),
    .full      (full),
    .empty     (empty),
    .level     (level)
  );

  // RAM model: registered one-cycle ack, optional stall. Each accepted
  // transaction is logged as {wr, addr, data}.
  logic [7:0]  ram [16];
  logic        ram_stall;
  logic [12:0] oplog [$];
  logic        ack_prev;
  int          gap_viol = 0;

  always @(posedge clk) begin
    if (!reset) begin
      dn_ack   <= 1'b0;
      ack_prev <= 1'b0;
    end else begin
      ack_prev <= dn_ack;
      if (ack_prev && dn_rq) gap_viol <= gap_viol + 1;
      if (dn_rq && !dn_ack && !ram_stall) begin
        dn_ack <= 1'b1;
        if (dn_wr_ni) begin
          ram[dn_address] <= dn_dataW;
          oplog.push_back({1'b1, dn_address, dn_dataW});
        end else begin
          dn_dataR <= ram[dn_address];
          oplog.push_back({1'b0, dn_address, ram[dn_address]});
        end
      end else begin
        dn_ack <= 1'b0;
      end
    end
  end

  int npass  = 0;
  int nfail  = 0;
  int ntotal = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_write(input logic [3:0] a, input logic [7:0] d, input int maxc,
                          output int cyc);
    @(negedge clk);
    up_address = a; up_dataW = d; up_wr_ni = 1'b1; up_rq = 1'b1;
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (!up_ack && cyc < maxc);
    up_rq = 1'b0;
  endtask

  task automatic do_read(input logic [3:0] a, input int maxc,
                         output int cyc, output logic [7:0] d);
    @(negedge clk);
    up_address = a; up_wr_ni = 1'b0; up_rq = 1'b1;
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (!up_ack && cyc < maxc);
    d = up_dataR;
    up_rq = 1'b0;
  endtask

  task automatic wait_empty(input string tag, input int maxc);
    for (int i = 0; i < maxc && !empty; i++) @(negedge clk);
    chk(tag, 32'(empty), 32'd1);
  endtask

  initial begin
    int          cyc;
    int          base;
    int          bad;
    logic        seen;
    logic [7:0]  rd;
    logic [11:0] exp_q [$];
    logic [11:0] ent;

    // Reset with a request held high.
    reset = 1'b0; ram_stall = 1'b0;
    up_rq = 1'b1; up_wr_ni = 1'b1; up_address = 4'h5; up_dataW = 8'hA7;
    repeat (2) @(negedge clk);
    chk("rst_up_ack",     32'(up_ack),     32'd0);
    chk("rst_up_dataR",   32'(up_dataR),   32'd0);
    chk("rst_dn_rq",      32'(dn_rq),      32'd0);
    chk("rst_dn_wr_ni",   32'(dn_wr_ni),   32'd0);
    chk("rst_dn_address", 32'(dn_address), 32'd0);
    chk("rst_dn_dataW",   32'(dn_dataW),   32'd0);
    chk("rst_empty",      32'(empty),      32'd1);
    chk("rst_full",       32'(full),       32'd0);
    chk("rst_level",      32'(level),      32'd0);
    up_rq = 1'b0;
    reset = 1'b1;

    // Single write, RAM stalled so the issued request can be observed.
    ram_stall = 1'b1;
    @(negedge clk);
    up_address = 4'h5; up_dataW = 8'hA7; up_wr_ni = 1'b1; up_rq = 1'b1;
    @(negedge clk);
    chk("wr_ack",    32'(up_ack), 32'd1);
    chk("wr_level1", 32'(level),  32'd1);
    up_rq = 1'b0;
    @(negedge clk);
    chk("wr_ack_one_cycle", 32'(up_ack),     32'd0);
    chk("wr_dn_rq",         32'(dn_rq),      32'd1);
    chk("wr_dn_wr_ni",      32'(dn_wr_ni),   32'd1);
    chk("wr_dn_address",    32'(dn_address), 32'h5);
    chk("wr_dn_dataW",      32'(dn_dataW),   32'hA7);
    repeat (3) @(negedge clk);
    chk("wr_dn_rq_hold", 32'(dn_rq), 32'd1);
    ram_stall = 1'b0;
    for (int i = 0; i < 10 && level != 3'd0; i++) @(negedge clk);
    chk("wr_level0",   32'(level), 32'd0);
    chk("wr_dn_rq_lo", 32'(dn_rq), 32'd0);
    chk("wr_log_size", 32'(oplog.size()), 32'd1);
    chk("wr_log_entry", 32'((oplog.size() > 0) ? oplog[0] : 13'h0), 32'({1'b1, 4'h5, 8'hA7}));

    // Fill with the RAM stalled; the 5th write must wait for the first pop.
    ram_stall = 1'b1;
    base = oplog.size();
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      do_write(4'(i), 8'h10 + 8'(i), 10, cyc);
      if (cyc != 1 || up_ack !== 1'b1) bad++;
    end
    chk("fill_ack_latency", 32'(bad),   32'd0);
    chk("fill_full",        32'(full),  32'd1);
    chk("fill_level4",      32'(level), 32'd4);
    @(negedge clk);
    up_address = 4'h4; up_dataW = 8'h14; up_wr_ni = 1'b1; up_rq = 1'b1;
    seen = 1'b0;
    repeat (4) begin @(negedge clk); if (up_ack) seen = 1'b1; end
    chk("full_holds_write", 32'(seen), 32'd0);
    ram_stall = 1'b0;
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (!up_ack && cyc < 10);
    chk("fifth_acked",     32'(up_ack), 32'd1);
    chk("fifth_ack_cycle", 32'(cyc),    32'd2);
    chk("pushpop_level4",  32'(level),  32'd4);
    up_rq = 1'b0;
    wait_empty("fill_drained", 100);
    chk("fill_log_size", 32'(oplog.size() - base), 32'd5);
    bad = 0;
    for (int i = 0; i < 5; i++)
      if (oplog.size() <= base + i || oplog[base + i] !== {1'b1, 4'(i), 8'h10 + 8'(i)}) bad++;
    chk("fill_ram_order", 32'(bad), 32'd0);

    // Read-after-write to the same address.
    do_write(4'h9, 8'h3C, 10, cyc);
    chk("raw_wr_ack", 32'(up_ack), 32'd1);
    base = oplog.size();
    do_read(4'h9, 50, cyc, rd);
    chk("raw_rd_ack",  32'(up_ack), 32'd1);
    chk("raw_rd_data", 32'(rd),     32'h3C);
`ifndef SRV_WRBUF_READ_FORWARD_EN
    chk("raw_log_size", 32'(oplog.size() - base), 32'd2);
    chk("raw_wr_first", 32'((oplog.size() > base) ? oplog[base] : 13'h0),
        32'({1'b1, 4'h9, 8'h3C}));
    chk("raw_rd_second", 32'((oplog.size() > base + 1) ? oplog[base + 1] : 13'h0),
        32'({1'b0, 4'h9, 8'h3C}));
`endif
    repeat (2) @(negedge clk);
    wait_empty("raw_drained", 50);

    // Read latency with empty FIFO and zero-wait RAM.
    repeat (2) @(negedge clk);
    do_read(4'h5, 20, cyc, rd);
    chk("rd_latency", 32'(cyc), 32'd3);
    chk("rd_data",    32'(rd),  32'hA7);
    @(negedge clk);
    chk("rd_ack_one_cycle", 32'(up_ack), 32'd0);

    // 16 random writes, the last 12 pushed against a full FIFO.
    repeat (2) @(negedge clk);
    base = oplog.size();
    ram_stall = 1'b1;
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      if (i == 4) ram_stall = 1'b0;
      ent = 12'($urandom);
      exp_q.push_back(ent);
      do_write(ent[11:8], ent[7:0], 20, cyc);
      if (up_ack !== 1'b1) bad++;
      if (i >= 4 && level !== 3'd4) bad++;
    end
    chk("sb_ack_and_level", 32'(bad), 32'd0);
    wait_empty("sb_drained", 200);
    chk("sb_count", 32'(oplog.size() - base), 32'd16);
    bad = 0;
    for (int i = 0; i < 16; i++)
      if (oplog.size() <= base + i || oplog[base + i] !== {1'b1, exp_q[i]}) bad++;
    chk("sb_entries", 32'(bad), 32'd0);

    // Reset mid-operation discards buffered writes.
    ram_stall = 1'b1;
    do_write(4'hA, 8'h01, 10, cyc);
    do_write(4'hB, 8'h02, 10, cyc);
    base = oplog.size();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_empty", 32'(empty), 32'd1);
    chk("midrst_level", 32'(level), 32'd0);
    chk("midrst_dn_rq", 32'(dn_rq), 32'd0);
    reset = 1'b1;
    ram_stall = 1'b0;
    repeat (10) @(negedge clk);
    chk("midrst_no_ram_write", 32'(oplog.size() - base), 32'd0);

`ifdef SRV_WRBUF_READ_FORWARD_EN
    // Read forwarded from the youngest matching buffered write.
    ram_stall = 1'b1;
    base = oplog.size();
    do_write(4'h2, 8'h11, 10, cyc);
    do_write(4'h2, 8'h22, 10, cyc);
    do_read(4'h2, 20, cyc, rd);
    chk("fwd_latency",  32'(cyc),      32'd1);
    chk("fwd_data",     32'(rd),       32'h22);
    chk("fwd_dn_write", 32'(dn_wr_ni), 32'd1);
    ram_stall = 1'b0;
    wait_empty("fwd_drained", 50);
    bad = 0;
    for (int i = base; i < oplog.size(); i++) if (oplog[i][12] !== 1'b1) bad++;
    chk("fwd_no_ram_read", 32'(bad), 32'd0);
`endif

    chk("dn_rq_gap", 32'(gap_viol), 32'd0);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
`default_nettype wire
